// File: rtl/m6800_eclock_sync.sv
// 68000-style E clock (E_LOW low / E_HIGH high clk8 periods) with edge strobes,
// plus the VPA/VMA synchronous-peripheral handshake that terminates via _vpaDTACK.
module m6800_eclock_sync #(
  parameter int E_LOW  = 6,
  parameter int E_HIGH = 4
) (
  input  logic       clk32,
  input  logic       _reset,
  input  logic       clk8_en_p,
  input  logic       clk8_en_n,
  input  logic       _cpuAS,
  input  logic       _cpuVPA,
  output logic       E,
  output logic       E_rising,
  output logic       E_falling,
  output logic       _cpuVMA,
  output logic       _vpaDTACK,
  output logic [3:0] ecnt,
  output logic [1:0] vpaState
);

  localparam logic [3:0] LAST       = 4'(E_LOW + E_HIGH - 1);
  localparam logic [3:0] RISE_AT    = 4'(E_LOW - 1);
  localparam logic [3:0] HIGH_FROM  = 4'(E_LOW);
  localparam logic [3:0] SYNC_LIMIT = 4'd2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [3:0] ecntNext;
  logic       asSampled;
  logic       vpaSampled;

  assign ecntNext = (ecnt == LAST) ? 4'd0 : ecnt + 4'd1;

  // E and its strobes are registered from the same enable so they line up with ecnt.
  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      ecnt      <= 4'd0;
      E         <= 1'b0;
      E_rising  <= 1'b0;
      E_falling <= 1'b0;
    end else if (clk8_en_p) begin
      ecnt      <= ecntNext;
      E         <= (ecntNext >= HIGH_FROM);
      E_rising  <= (ecnt == RISE_AT);
      E_falling <= (ecnt == LAST);
    end else begin
      E_rising  <= 1'b0;
      E_falling <= 1'b0;
    end
  end

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      asSampled  <= 1'b1;
      vpaSampled <= 1'b1;
    end else if (clk8_en_n) begin
      asSampled  <= _cpuAS;
      vpaSampled <= _cpuVPA;
    end
  end

  // Handshake: only AS ends a cycle; VPA is looked at solely to start one.
  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      vpaState  <= IDLE;
      _cpuVMA   <= 1'b1;
      _vpaDTACK <= 1'b1;
    end else if (clk8_en_p) begin
      case (vpaState)
        IDLE: begin
          if (!asSampled && !vpaSampled) vpaState <= SYNC;
        end
        SYNC: begin
          if (asSampled) begin
            vpaState <= IDLE;
          end else if (ecnt <= SYNC_LIMIT) begin
            vpaState <= ACTIVE;
            _cpuVMA  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (asSampled) begin
            vpaState <= IDLE;
            _cpuVMA  <= 1'b1;
          end else if (ecnt == LAST) begin
            vpaState  <= DONE;
            _vpaDTACK <= 1'b0;
          end
        end
        DONE: begin
          if (asSampled) begin
            vpaState  <= IDLE;
            _cpuVMA   <= 1'b1;
            _vpaDTACK <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m6800_eclock_sync.sv
// Directed bench for m6800_eclock_sync: default 6/4 instance plus a 5/5 instance.
module tb_m6800_eclock_sync;

  logic       clk32;
  logic       _reset;
  logic       clk8_en_p;
  logic       clk8_en_n;
  logic       _cpuAS;
  logic       _cpuVPA;

  logic       e_a, rise_a, fall_a, vma_a, dtack_a;
  logic [3:0] ecnt_a;
  logic [1:0] state_a;
  logic       e_b, rise_b, fall_b, vma_b, dtack_b;
  logic [3:0] ecnt_b;
  logic [1:0] state_b;

  int compared   = 0;
  int mismatched = 0;
  int exp_cnt    = 0;
  int rise_a_cnt = 0;
  int fall_a_cnt = 0;
  int rise_b_cnt = 0;
  int fall_b_cnt = 0;
  logic [3:0] exp_q[$];

  localparam int ST_IDLE = 0, ST_SYNC = 1, ST_ACTIVE = 2, ST_DONE = 3;

  m6800_eclock_sync dut (
    .clk32(clk32), ._reset(_reset), .clk8_en_p(clk8_en_p), .clk8_en_n(clk8_en_n),
    ._cpuAS(_cpuAS), ._cpuVPA(_cpuVPA), .E(e_a), .E_rising(rise_a), .E_falling(fall_a),
    ._cpuVMA(vma_a), ._vpaDTACK(dtack_a), .ecnt(ecnt_a), .vpaState(state_a)
  );

  m6800_eclock_sync #(.E_LOW(5), .E_HIGH(5)) dut55 (
    .clk32(clk32), ._reset(_reset), .clk8_en_p(clk8_en_p), .clk8_en_n(clk8_en_n),
    ._cpuAS(_cpuAS), ._cpuVPA(_cpuVPA), .E(e_b), .E_rising(rise_b), .E_falling(fall_b),
    ._cpuVMA(vma_b), ._vpaDTACK(dtack_b), .ecnt(ecnt_b), .vpaState(state_b)
  );

  // clock / reset / enables
  initial begin
    clk32 = 1'b0;
    forever #15 clk32 = ~clk32;
  end

  initial begin : enable_gen
    logic [1:0] ph;
    ph = 2'd3;
    clk8_en_p = 1'b0;
    clk8_en_n = 1'b0;
    forever begin
      @(negedge clk32);
      ph = ph + 2'd1;
      clk8_en_p = (ph == 2'd0);
      clk8_en_n = (ph == 2'd2);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic as_n, input logic vpa_n);
    _cpuAS  = as_n;
    _cpuVPA = vpa_n;
  endtask

  // Advance to just after the next clk8_en_p edge and check the counter/E of both instances.
  task automatic tick();
    int n;
    n = 0;
    do begin
      @(posedge clk32);
      n++;
    end while (!clk8_en_p && n < 8);
    check("enable_seen", 32'(clk8_en_p), 32'd1);
    #1;
    exp_cnt = (exp_cnt == 9) ? 0 : exp_cnt + 1;
    check("ecnt_a", 32'(ecnt_a), 32'(exp_cnt));
    check("ecnt_b", 32'(ecnt_b), 32'(exp_cnt));
    check("e_a", 32'(e_a), 32'(exp_cnt >= 6));
    check("e_b", 32'(e_b), 32'(exp_cnt >= 5));
  endtask

  task automatic advance_to(input int target);
    int guard;
    guard = 0;
    while (exp_cnt != target && guard < 20) begin
      tick();
      guard++;
    end
    check("advance_to", 32'(exp_cnt), 32'(target));
  endtask

  task automatic hs(input string tag, input logic vma, input logic dtack, input int st);
    check({tag, "_vma"}, 32'(vma_a), 32'(vma));
    check({tag, "_dtack"}, 32'(dtack_a), 32'(dtack));
    check({tag, "_state"}, 32'(state_a), 32'(st));
  endtask

  initial begin
    _reset = 1'b0;
    drive(1'b1, 1'b1);
    repeat (3) @(posedge clk32);
    #1;
    check("rst_ecnt", 32'(ecnt_a), 32'd0);
    check("rst_e", 32'(e_a), 32'd0);
    check("rst_rise", 32'(rise_a), 32'd0);
    check("rst_fall", 32'(fall_a), 32'd0);
    hs("rst", 1'b1, 1'b1, ST_IDLE);
    @(negedge clk32);
    _reset = 1'b1;
    exp_cnt = 0;

    // free-running E: 25 enables
    for (int i = 1; i <= 25; i++) exp_q.push_back(4'(i % 10));
    for (int i = 1; i <= 25; i++) begin
      logic [3:0] want;
      tick();
      want = exp_q.pop_front();
      check("seq_ecnt", 32'(ecnt_a), 32'(want));
      check("seq_rise_a", 32'(rise_a), 32'(want == 4'd6));
      check("seq_fall_a", 32'(fall_a), 32'(want == 4'd0));
      check("seq_rise_b", 32'(rise_b), 32'(want == 4'd5));
      check("seq_fall_b", 32'(fall_b), 32'(want == 4'd0));
      rise_a_cnt += int'(rise_a);
      fall_a_cnt += int'(fall_a);
      rise_b_cnt += int'(rise_b);
      fall_b_cnt += int'(fall_b);
      if (want == 4'd0 || want == 4'd5 || want == 4'd6) begin
        @(posedge clk32);
        #1;
        check("pulse_width_rise_a", 32'(rise_a), 32'd0);
        check("pulse_width_fall_a", 32'(fall_a), 32'd0);
        check("pulse_width_rise_b", 32'(rise_b), 32'd0);
        check("pulse_width_fall_b", 32'(fall_b), 32'd0);
      end
    end
    check("rise_a_count", 32'(rise_a_cnt), 32'd2);
    check("fall_a_count", 32'(fall_a_cnt), 32'd2);
    check("rise_b_count", 32'(rise_b_cnt), 32'd3);
    check("fall_b_count", 32'(fall_b_cnt), 32'd2);

    // VPA cycle starting at ecnt 0
    advance_to(0);
    drive(1'b0, 1'b0);
    tick(); hs("t2_sync", 1'b1, 1'b1, ST_SYNC);
    tick(); hs("t2_active", 1'b0, 1'b1, ST_ACTIVE);
    check("t2_active_ecnt", 32'(ecnt_a), 32'd2);
    while (exp_cnt != 9) begin
      tick(); hs("t2_hold", 1'b0, 1'b1, ST_ACTIVE);
    end
    tick(); hs("t2_dtack", 1'b0, 1'b0, ST_DONE);
    check("t2_dtack_with_fall", 32'(fall_a), 32'd1);
    drive(1'b0, 1'b1);
    tick(); hs("t2_vpa_ignored", 1'b0, 1'b0, ST_DONE);
    drive(1'b1, 1'b1);
    tick(); hs("t2_release", 1'b1, 1'b1, ST_IDLE);

    // VPA cycle starting too late (ecnt 4): waits for the next E cycle
    advance_to(4);
    drive(1'b0, 1'b0);
    tick(); hs("t3_sync", 1'b1, 1'b1, ST_SYNC);
    while (exp_cnt != 0) begin
      tick(); hs("t3_wait", 1'b1, 1'b1, ST_SYNC);
    end
    tick(); hs("t3_active", 1'b0, 1'b1, ST_ACTIVE);
    while (exp_cnt != 9) begin
      tick(); hs("t3_hold", 1'b0, 1'b1, ST_ACTIVE);
    end
    tick(); hs("t3_dtack", 1'b0, 1'b0, ST_DONE);
    drive(1'b1, 1'b1);
    tick(); hs("t3_release", 1'b1, 1'b1, ST_IDLE);

    // abort by AS during ACTIVE
    drive(1'b0, 1'b0);
    tick(); hs("t4_sync", 1'b1, 1'b1, ST_SYNC);
    tick(); hs("t4_active", 1'b0, 1'b1, ST_ACTIVE);
    while (exp_cnt != 7) begin
      tick(); hs("t4_hold", 1'b0, 1'b1, ST_ACTIVE);
    end
    drive(1'b1, 1'b0);
    tick(); hs("t4_abort", 1'b1, 1'b1, ST_IDLE);
    repeat (4) begin
      tick(); hs("t4_no_dtack", 1'b1, 1'b1, ST_IDLE);
    end
    drive(1'b1, 1'b1);
    advance_to(0);
    drive(1'b0, 1'b0);
    tick(); hs("t4b_sync", 1'b1, 1'b1, ST_SYNC);
    tick(); hs("t4b_active", 1'b0, 1'b1, ST_ACTIVE);
    while (exp_cnt != 9) begin
      tick(); hs("t4b_hold", 1'b0, 1'b1, ST_ACTIVE);
    end
    tick(); hs("t4b_dtack", 1'b0, 1'b0, ST_DONE);

    // reset during DONE while E is high
    while (exp_cnt != 7) begin
      tick(); hs("t5_done", 1'b0, 1'b0, ST_DONE);
    end
    check("t5_e_high_before", 32'(e_a), 32'd1);
    #5;
    _reset = 1'b0;
    #1;
    check("t5_async_ecnt", 32'(ecnt_a), 32'd0);
    check("t5_async_e", 32'(e_a), 32'd0);
    check("t5_async_ecnt_b", 32'(ecnt_b), 32'd0);
    hs("t5_async", 1'b1, 1'b1, ST_IDLE);
    drive(1'b1, 1'b1);
    repeat (3) @(negedge clk32);
    _reset = 1'b1;
    exp_cnt = 0;
    #1;
    check("t5_restart_ecnt", 32'(ecnt_a), 32'd0);
    repeat (3) begin
      tick(); hs("t5_after", 1'b1, 1'b1, ST_IDLE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
